// File: rtl/receive.sv
// Receive-side unpacker: loads a block of NBYTES bytes in one cycle and pops it out
// one byte per read strobe, oldest first. Optional feature: RECEIVE_OVERWRITE_EN.
module receive #(
  parameter  int NBYTES = 16,
  localparam int CW     = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*NBYTES-1:0] a,
  input  logic                load,
  input  logic                rd,
  output logic [7:0]          dataout,
  output logic                rbneout,
  output logic                rbfout,
  output logic [CW-1:0]       countout,
  output logic                ovf,
  output logic                udf
);

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [8*NBYTES-1:0] buf_q, buf_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                last_byte;
  logic [8*NBYTES-1:0] buf_popped;
  logic [CW-1:0]       count_popped;
  state_e              state_popped;

  // Pop result: head byte leaves, zero fill enters at the bottom.
  assign last_byte    = (count_q == CW'(1));
  assign buf_popped   = buf_q << 8;
  assign count_popped = count_q - CW'(1);
  assign state_popped = last_byte ? EMPTY : DRAIN;

  // NOTE: every next-state variable gets its hold value first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (state_q == EMPTY) begin
      if (rd) begin
        udf_d = 1'b1;
      end
      if (load) begin
        buf_d   = a;
        count_d = CW'(NBYTES);
        state_d = FULL;
      end
    end else if (load && rd && last_byte) begin
      // The final pop and the next block meet in the same cycle: seamless chain.
      buf_d   = a;
      count_d = CW'(NBYTES);
      state_d = FULL;
    end else if (load) begin
      ovf_d = 1'b1;
`ifdef RECEIVE_OVERWRITE_EN
      buf_d   = a;
      count_d = CW'(NBYTES);
      state_d = FULL;
`else
      if (rd) begin
        buf_d   = buf_popped;
        count_d = count_popped;
        state_d = state_popped;
      end
`endif
    end else if (rd) begin
      buf_d   = buf_popped;
      count_d = count_popped;
      state_d = state_popped;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous and takes priority over load/rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign dataout  = buf_q[8*NBYTES-1 -: 8];
  assign rbneout  = (count_q != '0);
  assign rbfout   = (count_q == CW'(NBYTES));
  assign countout = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule
